// File: rtl/jesd204b_rx_lane_align_if.sv
// jesd204b_rx_lane_align_if
// Lane data bundle for the JESD204B RX alignment stage. It carries the raw
// PHY lane (ready, 4-octet word, per-octet control flags) and the
// frame-aligned output stream.
//   master : PHY / producer side (drives the rx_* group, observes out_*)
//   slave  : aligner side (consumes rx_*, drives out_*)
interface jesd204b_rx_lane_align_if;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic [3:0]  rx_datak;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid;
  logic        out_sof;

  modport master (
    output rx_ready, rx_data, rx_datak,
    input  out_data, out_datak, out_valid, out_sof
  );

  modport slave (
    input  rx_ready, rx_data, rx_datak,
    output out_data, out_datak, out_valid, out_sof
  );
endinterface

// File: rtl/jesd204b_rx_lane_align.sv
// jesd204b_rx_lane_align
// Per-lane JESD204B receive alignment: code-group synchronization, SYNC~
// generation, ILAS start (/R/) detection, octet rotation so octet 0 of every
// output word is frame aligned, and invalid-control supervision with
// automatic resync after ERR_THR consecutive error words.
// Optional feature macro: JESD204B_RX_ERR_CNT_EN enables the saturating
// invalid-control-octet counter on err_cnt; without it err_cnt reads 0.
module jesd204b_rx_lane_align #(
  parameter int unsigned K_CNT   = 4,
  parameter int unsigned ERR_THR = 3
) (
  input  logic                           link_clk,
  input  logic                           link_reset,
  jesd204b_rx_lane_align_if.slave        lane,
  input  logic                           resync,
  input  logic                           err_clr,
  output logic                           sync_n,
  output logic [1:0]                     lane_state,
  output logic                           align_err,
  output logic [15:0]                    err_cnt
);

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cs_state_t;

  localparam logic [3:0] K_CNT_L   = K_CNT[3:0];
  localparam logic [3:0] ERR_THR_L = ERR_THR[3:0];

  // /K/ = K28.5
  function automatic logic is_k(input logic k, input logic [7:0] d);
    return k && (d == 8'hBC);
  endfunction

  // /R/ = K28.0
  function automatic logic is_r(input logic k, input logic [7:0] d);
    return k && (d == 8'h1C);
  endfunction

  // control octet outside the legal set
  function automatic logic is_invalid(input logic k, input logic [7:0] d);
    logic bad;
    if (!k) begin
      bad = 1'b0;
    end else begin
      case (d)
        8'h1C, 8'h7C, 8'h9C, 8'hBC, 8'hFC: bad = 1'b0;
        default:                           bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  cs_state_t   state_q;
  logic [3:0]  kcnt_q;
  logic [3:0]  errw_q;
  logic [1:0]  offset_q;
  logic        first_q;
  logic        sync_n_q;
  logic        out_valid_q;
  logic        out_sof_q;
  logic        align_err_q;
  logic [31:0] prev_data_q;
  logic [3:0]  prev_k_q;
  logic [31:0] out_data_q;
  logic [3:0]  out_datak_q;
  logic [31:0] out_data_d;
  logic [3:0]  out_datak_d;

  logic [3:0]  oct_is_k;
  logic [3:0]  oct_is_r;
  logic [3:0]  oct_inv;
  logic [3:0]  krun;
  logic        nk_found;
  logic [1:0]  nk_idx;
  logic        step_ok;
  logic        err_word;
  logic        err_thr_hit;
  logic        init_go;
  logic        chk_r;
  logic        chk_fail;
  logic        drop;
  logic        emit;
  logic [55:0] comb_data;
  logic [6:0]  comb_k;

  // classify each incoming octet
  always_comb begin
    oct_is_k = 4'd0;
    oct_is_r = 4'd0;
    oct_inv  = 4'd0;
    for (int b = 0; b < 4; b++) begin
      oct_is_k[b] = is_k(lane.rx_datak[b], lane.rx_data[8*b +: 8]);
      oct_is_r[b] = is_r(lane.rx_datak[b], lane.rx_data[8*b +: 8]);
      oct_inv[b]  = is_invalid(lane.rx_datak[b], lane.rx_data[8*b +: 8]);
    end
  end

  // run the /K/ counter across octets 0..3 in time order
  always_comb begin
    krun = kcnt_q;
    for (int b = 0; b < 4; b++) begin
      if (oct_is_k[b]) begin
        if (krun != 4'hF) begin
          krun = krun + 4'd1;
        end else begin
          krun = krun;
        end
      end else begin
        krun = 4'd0;
      end
    end
  end

  // lowest-index octet that is not /K/
  always_comb begin
    nk_found = 1'b1;
    nk_idx   = 2'd0;
    casez (oct_is_k)
      4'b???0: nk_idx = 2'd0;
      4'b??01: nk_idx = 2'd1;
      4'b?011: nk_idx = 2'd2;
      4'b0111: nk_idx = 2'd3;
      default: begin
        nk_found = 1'b0;
        nk_idx   = 2'd0;
      end
    endcase
  end

  // The FSM only advances on a word when the lane is ready and no resync
  // is requested; otherwise it is forced back to CS_INIT.
  assign step_ok     = lane.rx_ready && !resync;
  assign err_word    = |oct_inv;
  assign err_thr_hit = err_word && (({1'b0, errw_q} + 5'd1) >= {1'b0, ERR_THR_L});
  assign init_go     = step_ok && (state_q == CS_INIT) && (krun >= K_CNT_L) && oct_is_k[3];
  assign chk_r       = step_ok && (state_q == CS_CHECK) && nk_found && oct_is_r[nk_idx];
  assign chk_fail    = step_ok && (state_q == CS_CHECK) && nk_found && !oct_is_r[nk_idx];
  assign drop        = !step_ok || chk_fail || ((state_q == CS_DATA) && err_thr_hit);
  assign emit        = (state_q == CS_DATA) && !drop;

  // rotate {current, previous} by the latched offset
  assign comb_data = {lane.rx_data[23:0], prev_data_q};
  assign comb_k    = {lane.rx_datak[2:0], prev_k_q};

  // select the frame-aligned 4-octet window
  always_comb begin
    out_data_d  = comb_data[31:0];
    out_datak_d = comb_k[3:0];
    case (offset_q)
      2'd0: begin
        out_data_d  = comb_data[31:0];
        out_datak_d = comb_k[3:0];
      end
      2'd1: begin
        out_data_d  = comb_data[39:8];
        out_datak_d = comb_k[4:1];
      end
      2'd2: begin
        out_data_d  = comb_data[47:16];
        out_datak_d = comb_k[5:2];
      end
      2'd3: begin
        out_data_d  = comb_data[55:24];
        out_datak_d = comb_k[6:3];
      end
      default: begin
        out_data_d  = comb_data[31:0];
        out_datak_d = comb_k[3:0];
      end
    endcase
  end

  // CGS / ILAS / data-supervision state machine with registered outputs
  always_ff @(posedge link_clk) begin
    if (link_reset) begin
      state_q     <= CS_INIT;
      kcnt_q      <= 4'd0;
      errw_q      <= 4'd0;
      offset_q    <= 2'd0;
      first_q     <= 1'b0;
      sync_n_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= chk_fail;
      if (drop) begin
        state_q     <= CS_INIT;
        kcnt_q      <= 4'd0;
        errw_q      <= 4'd0;
        offset_q    <= 2'd0;
        first_q     <= 1'b0;
        sync_n_q    <= 1'b0;
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
      end else begin
        case (state_q)
          CS_INIT: begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            if (init_go) begin
              state_q  <= CS_CHECK;
              sync_n_q <= 1'b1;
              kcnt_q   <= 4'd0;
            end else begin
              kcnt_q <= krun;
            end
          end
          CS_CHECK: begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            if (chk_r) begin
              state_q  <= CS_DATA;
              offset_q <= nk_idx;
              first_q  <= 1'b1;
            end else begin
              state_q <= CS_CHECK;
            end
          end
          CS_DATA: begin
            errw_q      <= err_word ? (errw_q + 4'd1) : 4'd0;
            out_valid_q <= 1'b1;
            out_sof_q   <= first_q;
            first_q     <= 1'b0;
          end
          default: begin
            state_q     <= CS_INIT;
            kcnt_q      <= 4'd0;
            errw_q      <= 4'd0;
            offset_q    <= 2'd0;
            first_q     <= 1'b0;
            sync_n_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // previous-word history and aligned output word
  always_ff @(posedge link_clk) begin
    if (link_reset) begin
      prev_data_q <= 32'd0;
      prev_k_q    <= 4'd0;
      out_data_q  <= 32'd0;
      out_datak_q <= 4'd0;
    end else begin
      prev_data_q <= lane.rx_data;
      prev_k_q    <= lane.rx_datak;
      if (emit) begin
        out_data_q  <= out_data_d;
        out_datak_q <= out_datak_d;
      end else begin
        out_data_q  <= out_data_q;
        out_datak_q <= out_datak_q;
      end
    end
  end

`ifdef JESD204B_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [2:0]  inv_octets;
  logic [16:0] err_sum;

  // number of invalid control octets in this word and the widened sum
  always_comb begin
    inv_octets = 3'd0;
    for (int b = 0; b < 4; b++) begin
      inv_octets = inv_octets + {2'd0, oct_inv[b]};
    end
    err_sum = {1'b0, err_cnt_q} + {14'd0, inv_octets};
  end

  // saturating invalid-octet counter; a clear request beats new errors
  always_ff @(posedge link_clk) begin
    if (link_reset) begin
      err_cnt_q <= 16'd0;
    end else if (err_clr) begin
      err_cnt_q <= 16'd0;
    end else if (step_ok && (state_q == CS_DATA)) begin
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = 16'd0;
`endif

  assign sync_n         = sync_n_q;
  assign lane_state     = state_q;
  assign align_err      = align_err_q;
  assign lane.out_data  = out_data_q;
  assign lane.out_datak = out_datak_q;
  assign lane.out_valid = out_valid_q;
  assign lane.out_sof   = out_sof_q;

endmodule

// File: tb/tb_jesd204b_rx_lane_align.sv
// tb_jesd204b_rx_lane_align
// Self-checking bench: every aligned word the lane should emit is pushed to a
// scoreboard when the input word completing it is driven, and popped and
// compared when the DUT presents it. Control outputs are checked directly.
module tb_jesd204b_rx_lane_align;

  logic        link_clk = 1'b0;
  logic        link_reset;
  logic        resync;
  logic        err_clr;
  logic        sync_n;
  logic [1:0]  lane_state;
  logic        align_err;
  logic [15:0] err_cnt;

  jesd204b_rx_lane_align_if lif ();

  jesd204b_rx_lane_align #(
    .K_CNT   (4),
    .ERR_THR (3)
  ) dut (
    .link_clk   (link_clk),
    .link_reset (link_reset),
    .lane       (lif),
    .resync     (resync),
    .err_clr    (err_clr),
    .sync_n     (sync_n),
    .lane_state (lane_state),
    .align_err  (align_err),
    .err_cnt    (err_cnt)
  );

  always #5 link_clk = ~link_clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        sof;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_d = 32'd0;
  logic [3:0]  last_k = 4'd0;
  bit          exp_on = 1'b0;
  bit          exp_first = 1'b0;
  int          exp_o = 0;
  logic [15:0] exp_err = 16'd0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, act, exp);
    end
  endtask

  // one clock; sample 1 ns after the edge and service the scoreboard
  task automatic tick();
    exp_t e;
    bit   want_valid;
    @(posedge link_clk);
    #1;
    want_valid = (sb_q.size() > 0);
    check_val("out_valid", 64'(lif.out_valid), 64'(want_valid));
    check_val("sof_without_valid", 64'(lif.out_sof & ~lif.out_valid), 64'd0);
    if (want_valid) begin
      e = sb_q.pop_front();
      if (lif.out_valid) begin
        check_val("out_data", 64'(lif.out_data), 64'(e.d));
        check_val("out_datak", 64'(lif.out_datak), 64'(e.k));
        check_val("out_sof", 64'(lif.out_sof), 64'(e.sof));
      end
    end
  endtask

  // drive one lane word; if alignment is expected, queue the aligned word it completes
  task automatic drive(input logic [31:0] d, input logic [3:0] k);
    logic [63:0] cd;
    logic [7:0]  ck;
    exp_t        e;
    lif.rx_data  = d;
    lif.rx_datak = k;
    if (exp_on) begin
      cd        = {d, last_d} >> (8 * exp_o);
      ck        = {k, last_k} >> exp_o;
      e.d       = cd[31:0];
      e.k       = ck[3:0];
      e.sof     = exp_first;
      exp_first = 1'b0;
      sb_q.push_back(e);
    end
    last_d = d;
    last_k = k;
    tick();
    resync  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic expect_align(input int o);
    exp_on    = 1'b1;
    exp_o     = o;
    exp_first = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic [1:0] st, input logic sn);
    check_val({tag, "_state"}, 64'(lane_state), 64'(st));
    check_val({tag, "_sync_n"}, 64'(sync_n), 64'(sn));
  endtask

  initial begin
    link_reset   = 1'b1;
    resync       = 1'b0;
    err_clr      = 1'b0;
    lif.rx_ready = 1'b0;
    lif.rx_data  = 32'd0;
    lif.rx_datak = 4'd0;
    repeat (3) tick();
    check_state("reset", 2'd0, 1'b0);
    check_val("reset_out_data", 64'(lif.out_data), 64'd0);
    check_val("reset_out_datak", 64'(lif.out_datak), 64'd0);
    check_val("reset_align_err", 64'(align_err), 64'd0);
    check_val("reset_err_cnt", 64'(err_cnt), 64'd0);
    link_reset   = 1'b0;
    lif.rx_ready = 1'b1;
    drive(32'd0, 4'h0);
    check_state("idle", 2'd0, 1'b0);

    // CGS with /R/ at octet 0
    drive(32'hBCBCBCBC, 4'hF);
    check_state("cgs1_k1", 2'd1, 1'b1);
    drive(32'hBCBCBCBC, 4'hF);
    drive(32'hBCBCBCBC, 4'hF);
    check_state("cgs1_k3", 2'd1, 1'b1);
    drive(32'h0302011C, 4'h1);
    check_state("cgs1_r", 2'd2, 1'b1);
    expect_align(0);
    for (int i = 0; i < 6; i++) begin
      drive(32'h07060504 + 32'h04040404 * i, 4'h0);
    end
    check_state("cgs1_data", 2'd2, 1'b1);

    // resync, then CGS with /R/ at octet 2 and 100 data words
    exp_on = 1'b0;
    resync = 1'b1;
    drive(32'h11111111, 4'h0);
    check_state("resync_data", 2'd0, 1'b0);
    drive(32'hBCBCBCBC, 4'hF);
    check_state("cgs2_k", 2'd1, 1'b1);
    drive(32'h011CBCBC, 4'h7);
    check_state("cgs2_r", 2'd2, 1'b1);
    expect_align(2);
    for (int i = 0; i < 100; i++) begin
      drive($urandom(), 4'h0);
    end
    check_state("off2_held", 2'd2, 1'b1);

    // alignment error: first non-/K/ octet is plain data
    exp_on = 1'b0;
    resync = 1'b1;
    drive(32'h22222222, 4'h0);
    drive(32'hBCBCBCBC, 4'hF);
    check_state("cgs3_k", 2'd1, 1'b1);
    drive(32'h55BCBCBC, 4'h7);
    check_val("align_err_pulse", 64'(align_err), 64'd1);
    check_state("align_err", 2'd0, 1'b0);
    drive(32'h00000000, 4'h0);
    check_val("align_err_end", 64'(align_err), 64'd0);

    // error words in CS_DATA
    drive(32'hBCBCBCBC, 4'hF);
    drive(32'h0302011C, 4'h1);
    check_state("cgs4_r", 2'd2, 1'b1);
    expect_align(0);
    drive(32'h33220011, 4'h2);
    drive(32'h33220011, 4'h2);
    check_state("two_err", 2'd2, 1'b1);
`ifdef JESD204B_RX_ERR_CNT_EN
    exp_err = 16'd2;
`endif
    check_val("err_cnt_two", 64'(err_cnt), 64'(exp_err));
    err_clr = 1'b1;
    drive(32'h44444444, 4'h0);
    check_state("clean_word", 2'd2, 1'b1);
    check_val("err_cnt_clr", 64'(err_cnt), 64'd0);
    drive(32'h33220011, 4'h2);
    drive(32'h33220011, 4'h2);
    check_state("err_2of3", 2'd2, 1'b1);
    exp_on = 1'b0;
    drive(32'h33220011, 4'h2);
    check_state("err_3of3", 2'd0, 1'b0);
`ifdef JESD204B_RX_ERR_CNT_EN
    exp_err = 16'd3;
`else
    exp_err = 16'd0;
`endif
    check_val("err_cnt_three", 64'(err_cnt), 64'(exp_err));

    // rx_ready low mid-CS_DATA
    drive(32'hBCBCBCBC, 4'hF);
    drive(32'h0302011C, 4'h1);
    expect_align(0);
    for (int i = 0; i < 3; i++) begin
      drive(32'hA0A1A2A3 + i, 4'h0);
    end
    exp_on       = 1'b0;
    lif.rx_ready = 1'b0;
    drive(32'hBCBCBCBC, 4'hF);
    check_state("rdy_low", 2'd0, 1'b0);
    drive(32'hBCBCBCBC, 4'hF);
    check_state("rdy_low_held", 2'd0, 1'b0);
    lif.rx_ready = 1'b1;
    drive(32'hBCBCBC00, 4'hE);
    check_state("rdy_k3", 2'd0, 1'b0);
    drive(32'hBCBCBCBC, 4'hF);
    check_state("rdy_k4", 2'd1, 1'b1);

    // resync pulse in CS_CHECK
    resync = 1'b1;
    drive(32'hBCBCBCBC, 4'hF);
    check_state("chk_resync", 2'd0, 1'b0);
    drive(32'h0302011C, 4'h1);
    check_state("chk_resync_r", 2'd0, 1'b0);

    // link_reset while three /K/ octets are counted
    drive(32'hBCBCBC00, 4'hE);
    check_state("cnt3", 2'd0, 1'b0);
    link_reset = 1'b1;
    drive(32'hBCBCBCBC, 4'hF);
    check_state("rst_mid", 2'd0, 1'b0);
    link_reset = 1'b0;
    drive(32'hBCBCBC00, 4'hE);
    check_state("rst_k3", 2'd0, 1'b0);
    drive(32'hBCBCBCBC, 4'hF);
    check_state("rst_k4", 2'd1, 1'b1);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
